// File: rtl/ldtu_rx_pkg.sv
// Shared definitions for the LiTe-DTU output word receiver.
// Holds the idle patterns, the lock state encoding and the idle-word classifier.
package ldtu_rx_pkg;

  localparam logic [31:0] IDLE_PATTERN_EA = 32'hEAAAAAAA;
  localparam logic [31:0] IDLE_PATTERN_5A = 32'h5A5A5A5A;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } rx_state_e;

  // Exact match against either idle pattern; everything else is payload.
  function automatic logic is_idle_word(input logic [31:0] word);
    return (word == IDLE_PATTERN_EA) || (word == IDLE_PATTERN_5A);
  endfunction

endpackage

// File: rtl/dtu_rx_fifo.sv
// First-word-fall-through payload FIFO with wrap-bit pointers.
// Head word and valid flag are registered from the next-state pointers.
module dtu_rx_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PTR_BITS = 3
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        i_push,
  input  logic [31:0] i_wdata,
  input  logic        i_pop,
  output logic [31:0] o_rdata,
  output logic        o_valid,
  output logic        o_full_c
);

  localparam int unsigned PW = PTR_BITS + 1;

  logic [31:0]         r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW-1:0]       w_wr_ptr_nxt;
  logic [PW-1:0]       w_rd_ptr_nxt;
  logic [PTR_BITS-1:0] w_wr_addr;
  logic [PTR_BITS-1:0] w_rd_addr_nxt;
  logic                w_empty;
  logic                w_empty_nxt;
  logic                w_do_push;
  logic                w_do_pop;
  logic [31:0]         w_head_nxt;

  assign w_wr_addr = r_wr_ptr[PTR_BITS-1:0];
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full_c  = (r_wr_ptr[PTR_BITS-1:0] == r_rd_ptr[PTR_BITS-1:0]) &&
                     (r_wr_ptr[PTR_BITS] != r_rd_ptr[PTR_BITS]);

  // A pop on empty is ignored; a push on full only proceeds alongside a pop.
  always_comb begin
    w_do_pop      = i_pop & ~w_empty;
    w_do_push     = i_push & (~o_full_c | w_do_pop);
    w_wr_ptr_nxt  = r_wr_ptr + PW'(w_do_push);
    w_rd_ptr_nxt  = r_rd_ptr + PW'(w_do_pop);
    w_rd_addr_nxt = w_rd_ptr_nxt[PTR_BITS-1:0];
    w_empty_nxt   = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    // Bypass the incoming word when it becomes the new head this edge.
    if (w_do_push && (w_rd_addr_nxt == w_wr_addr)) begin
      w_head_nxt = i_wdata;
    end else begin
      w_head_nxt = r_mem[w_rd_addr_nxt];
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push) begin
      r_mem[w_wr_addr] <= i_wdata;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_rdata  <= '0;
      o_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      o_rdata  <= w_empty_nxt ? 32'h0 : w_head_nxt;
      o_valid  <= ~w_empty_nxt;
    end
  end

endmodule

// File: rtl/dtu_word_receiver.sv
// Receiver for the LiTe-DTU 32-bit output stream: idle-based word lock,
// idle stripping, payload buffering and status counters.
module dtu_word_receiver
  import ldtu_rx_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_BITS   = 3,
  parameter int unsigned LOCK_IDLES = 4,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [31:0]         word_in,
  input  logic                word_valid,
  input  logic                resync,
  output logic [31:0]         data_out,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                locked,
  output logic [CNT_BITS-1:0] idle_count,
  output logic [CNT_BITS-1:0] data_count,
  output logic                overflow
);

  localparam int unsigned RUN_BITS = $clog2(LOCK_IDLES + 1);

  rx_state_e           r_state;
  rx_state_e           w_state_nxt;
  logic [RUN_BITS-1:0] r_run;
  logic [RUN_BITS-1:0] w_run_nxt;
  logic                w_is_idle;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_idle_inc;
  logic                w_full_c;

  assign w_is_idle = is_idle_word(word_in);
  assign w_pop     = data_valid & data_ready;
  assign locked    = (r_state == LOCKED);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= UNLOCKED;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
    end
  end

  // Lock FSM; resync wins over any word presented in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_idle_inc  = 1'b0;
    if (resync) begin
      w_state_nxt = UNLOCKED;
      w_run_nxt   = '0;
    end else if (word_valid) begin
      if (r_state == UNLOCKED) begin
        if (w_is_idle) begin
          w_run_nxt = r_run + RUN_BITS'(1);
          if (r_run == RUN_BITS'(LOCK_IDLES - 1)) begin
            w_state_nxt = LOCKED;
          end
        end else begin
          w_run_nxt = '0;
        end
      end else begin
        if (w_is_idle) begin
          w_idle_inc = 1'b1;
        end else if (!w_full_c || w_pop) begin
          w_push = 1'b1;
        end else begin
          w_drop      = 1'b1;
          w_state_nxt = UNLOCKED;
          w_run_nxt   = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      idle_count <= '0;
      data_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (w_idle_inc && (idle_count != '1)) begin
        idle_count <= idle_count + CNT_BITS'(1);
      end
      if (w_push && (data_count != '1)) begin
        data_count <= data_count + CNT_BITS'(1);
      end
      if (w_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  dtu_rx_fifo #(
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_fifo (
    .CLK      (CLK),
    .reset    (reset),
    .i_push   (w_push),
    .i_wdata  (word_in),
    .i_pop    (w_pop),
    .o_rdata  (data_out),
    .o_valid  (data_valid),
    .o_full_c (w_full_c)
  );

endmodule
